seg7_scan_driver: RTL and testbench

- Downstream display stage for the processor top level: consumes the 16-bit processor output bus and drives a 4-digit, common-anode, multiplexed seven-segment display on the FPGA board.
- Captures the value on a valid strobe, decodes each nibble to hex glyphs and time-multiplexes the digits with a programmable refresh period.
- Provides an anti-ghosting blank window and optional leading-zero suppression.

---
 rtl/seg7_scan_driver_if.sv | 9 +
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Capture bus from the processor into the seven-segment display stage.
// Valid-only handshake: data_in is taken on every rising clk edge where data_valid is 1; there is no ready, the sink always accepts.
interface seg7_scan_driver_if;
    logic [15:0] data_in;
    logic        data_valid;

    modport master (output data_in, output data_valid);
    modport slave  (input  data_in, input  data_valid);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// Latches a 16-bit value and shows it as hex, with an anti-ghosting blank window and leading-zero blanking.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 17
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus,
    input  logic                blank_lz,
    input  logic [3:0]          dp_en,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    logic [15:0]      shown_q, shown_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             lz;
    logic             blank;

    always_comb begin
        shown_d = shown_q;
        if (bus.data_valid) begin
            shown_d = bus.data_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (int'(cnt_q) == REFRESH_DIV - 1) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz = 1'b0;
        case (idx_q)
            2'd0:    lz = 1'b0;
            2'd1:    lz = (shown_q[15:4] == 12'h000);
            2'd2:    lz = (shown_q[15:8] == 8'h00);
            default: lz = (shown_q[15:12] == 4'h0);
        endcase
        lz = lz & blank_lz;
    end

    assign nibble = shown_q[{idx_q, 2'b00} +: 4];

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        glyph = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

    always_comb begin
        blank = (int'(cnt_q) < BLANK_CYCLES) | lz;
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = glyph;
            dp_d  = ~dp_en[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown_q <= 16'h0000;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            shown_q <= shown_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

    a_one_anode: assert property (@(posedge clk) disable iff (rst) $countones(~an_q) <= 1);
    a_cnt_range: assert property (@(posedge clk) disable iff (rst) int'(cnt_q) < REFRESH_DIV);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected glyphs are hand-computed per vector; slot timing comes from counting edges since reset release.
module tb_seg7_scan_driver;
  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;

  typedef struct {
    logic [15:0]     data;
    logic            lz;
    logic [3:0]      dpe;
    logic [3:0]      lit;
    logic [3:0][6:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  logic       clk;
  logic       rst;
  logic       blank_lz;
  logic [3:0] dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks;
  int fails;
  int edges;

  vec_t            vecs [8];
  logic [3:0][3:0] an_tbl;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .CNT_W       (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .blank_lz(blank_lz),
    .dp_en   (dp_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // clock / reset-relative edge count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got edges=%0d required test end", edges);
    $fatal(1, "watchdog");
  end

  // scoreboard check
  task automatic expect_out(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp);
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || $countones(~an) > 1) begin
      fails++;
      $display("FAIL %s @edge %0d: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
               name, edges, an, seg, dp, e_an, e_seg, e_dp);
    end
  endtask

  // driver tasks
  task automatic strobe(input logic [15:0] d);
    @(negedge clk);
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic align_frame();
    while (edges % FRAME != 0) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input vec_t v);
    int c;
    int i;
    logic blk;
    align_frame();
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      c   = (edges - 1) % RDIV;
      i   = ((edges - 1) / RDIV) % 4;
      blk = (c < BLANK) || !v.lit[i];
      expect_out(name, blk ? 4'b1111 : an_tbl[i], blk ? 7'h7F : v.segs[i],
                 blk ? 1'b1 : ~v.dpe[i]);
    end
  endtask

  task automatic check_release(input string name);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out({name, "_e1"}, 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    expect_out({name, "_e2"}, 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    expect_out({name, "_e3"}, 4'b1110, 7'h40, 1'b1);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    fails  = 0;
    an_tbl = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    vecs[0] = '{16'h1A2F, 1'b0, 4'b0000, 4'b1111, {7'h79, 7'h08, 7'h24, 7'h0E}};
    vecs[1] = '{16'h0030, 1'b1, 4'b0000, 4'b0011, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vecs[2] = '{16'h0030, 1'b0, 4'b0000, 4'b1111, {7'h40, 7'h40, 7'h30, 7'h40}};
    vecs[3] = '{16'h0000, 1'b1, 4'b0000, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{16'h89AB, 1'b0, 4'b0100, 4'b1111, {7'h00, 7'h10, 7'h08, 7'h03}};
    vecs[5] = '{16'h0500, 1'b1, 4'b1011, 4'b0111, {7'h7F, 7'h12, 7'h40, 7'h40}};
    vecs[6] = '{16'hC6D7, 1'b1, 4'b0000, 4'b1111, {7'h46, 7'h02, 7'h21, 7'h78}};
    vecs[7] = '{16'h3E45, 1'b0, 4'b1111, 4'b1111, {7'h30, 7'h06, 7'h19, 7'h12}};

    rst            = 1'b1;
    bus.data_in    = 16'h0000;
    bus.data_valid = 1'b0;
    blank_lz       = 1'b0;
    dp_en          = 4'b0000;
    #1;
    expect_out("reset_state", 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    check_release("first_release");

    for (int n = 0; n < 8; n++) begin
      blank_lz = vecs[n].lz;
      dp_en    = vecs[n].dpe;
      strobe(vecs[n].data);
      check_frame($sformatf("vec%0d", n), vecs[n]);
    end

    // back-to-back strobes: last one wins
    blank_lz = 1'b0;
    dp_en    = 4'b0000;
    @(negedge clk);
    bus.data_in    = 16'hFFFF;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_in    = 16'h8888;
    @(negedge clk);
    bus.data_valid = 1'b0;
    v = '{16'h8888, 1'b0, 4'b0000, 4'b1111, {7'h00, 7'h00, 7'h00, 7'h00}};
    check_frame("back_to_back", v);

    // capture latency: old value on the capture edge, new value one edge later
    while (edges % FRAME != 2) @(negedge clk);
    bus.data_in    = 16'h0001;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    expect_out("capture_edge_old", 4'b1110, 7'h00, 1'b1);
    @(negedge clk);
    expect_out("capture_plus1_new", 4'b1110, 7'h79, 1'b1);

    // asynchronous reset mid-slot, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_reset", 4'b1111, 7'h7F, 1'b1);
    check_release("second_release");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
